uart_cmd_rx: RTL and testbench

Serial command receiver for the home-appliance controller, the inbound counterpart of the sensor-report UART transmitter. It oversamples the `rx` line, deframes 8N1 bytes, and parses ASCII command lines of the form `X:ddd` terminated by CR or LF. Each valid line yields a one-cycle command strobe carrying the letter code and a decimal value. Malformed lines yield an error strobe. Its outputs feed the mode and setpoint registers of the system controller.

---
 rtl/uart_cmd_rx.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: oversampling UART receiver with an ASCII "X:ddd" command-line parser.
//
// Optional feature: define UART_CMD_PARITY_EN for 8E1 framing (even parity bit
// between the last data bit and the stop bit). Undefined: plain 8N1.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   rx         in   asynchronous serial input, idle high
//   byte_valid out  one-cycle strobe per correctly framed byte
//   byte_data  out  last received byte, held until next byte_valid
//   cmd_valid  out  one-cycle strobe per valid command line
//   cmd_code   out  command letter 'A'..'Z', held until next cmd_valid
//   cmd_value  out  decimal value 0..999, held until next cmd_valid
//   cmd_err    out  one-cycle strobe on framing/parity/syntax/overflow error
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OVS      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [9:0] cmd_value,
    output logic       cmd_err
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVS);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int unsigned HALF  = OVS / 2;

`ifdef UART_CMD_PARITY_EN
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_HI} rx_state_t;
`else
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_HI} rx_state_t;
`endif
    typedef enum logic [1:0] {P_IDLE, P_COLON, P_DIGIT, P_FLUSH} p_state_t;

    rx_state_t        rstate;
    p_state_t         pstate;
    logic             rx_meta;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic [OVS_W-1:0] ovs_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       code_q;
    logic [9:0]       acc;
    logic [1:0]       dcnt;
    logic             tick_c;
    logic             ovs_last_c;
    logic             stop_sample_c;
    logic             par_ok_c;
    logic             frame_bad_c;
    logic             is_eol_c;
    logic             is_letter_c;
    logic             is_digit_c;

    // Two-flop synchronizer, idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick_c        = (div_cnt == DIV_W'(DIV - 1));
    assign ovs_last_c    = (ovs_cnt == OVS_W'(OVS - 1));
    assign stop_sample_c = (rstate == R_STOP) && tick_c && ovs_last_c;

`ifdef UART_CMD_PARITY_EN
    logic par_bad;
    assign par_ok_c = !par_bad;
`else
    assign par_ok_c = 1'b1;
`endif

    // Bad stop bit or parity mismatch at the stop sample
    assign frame_bad_c = stop_sample_c && !(rx_s && par_ok_c);

    // Receiver: divider, oversample counter and deframing FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rstate     <= R_IDLE;
            div_cnt    <= '0;
            ovs_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
`ifdef UART_CMD_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            div_cnt    <= tick_c ? '0 : div_cnt + DIV_W'(1);
            case (rstate)
                R_IDLE: begin
                    // Realign the bit grid to the detected falling edge
                    if (!rx_s) begin
                        div_cnt <= '0;
                        ovs_cnt <= '0;
                        rstate  <= R_START;
                    end
                end
                R_START: begin
                    if (tick_c) begin
                        if (ovs_cnt == OVS_W'(HALF - 1)) begin
                            ovs_cnt <= '0;
                            bit_cnt <= '0;
                            rstate  <= rx_s ? R_IDLE : R_DATA;
                        end else begin
                            ovs_cnt <= ovs_cnt + OVS_W'(1);
                        end
                    end
                end
                R_DATA: begin
                    if (tick_c) begin
                        if (ovs_last_c) begin
                            ovs_cnt <= '0;
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                                rstate <= R_PARITY;
`else
                                rstate <= R_STOP;
`endif
                            end
                        end else begin
                            ovs_cnt <= ovs_cnt + OVS_W'(1);
                        end
                    end
                end
`ifdef UART_CMD_PARITY_EN
                R_PARITY: begin
                    if (tick_c) begin
                        if (ovs_last_c) begin
                            ovs_cnt <= '0;
                            par_bad <= rx_s ^ (^shreg);
                            rstate  <= R_STOP;
                        end else begin
                            ovs_cnt <= ovs_cnt + OVS_W'(1);
                        end
                    end
                end
`endif
                R_STOP: begin
                    if (tick_c) begin
                        if (ovs_last_c) begin
                            ovs_cnt <= '0;
                            if (rx_s && par_ok_c) begin
                                byte_valid <= 1'b1;
                                byte_data  <= shreg;
                            end
                            rstate <= rx_s ? R_IDLE : R_WAIT_HI;
                        end else begin
                            ovs_cnt <= ovs_cnt + OVS_W'(1);
                        end
                    end
                end
                R_WAIT_HI: begin
                    if (rx_s) rstate <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign is_eol_c    = (byte_data == 8'h0D) || (byte_data == 8'h0A);
    assign is_letter_c = (byte_data >= 8'h41) && (byte_data <= 8'h5A);
    assign is_digit_c  = (byte_data >= 8'h30) && (byte_data <= 8'h39);

    // Line parser; framing errors and byte strobes never coincide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pstate    <= P_IDLE;
            code_q    <= '0;
            acc       <= '0;
            dcnt      <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_value <= '0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= frame_bad_c;
            if (frame_bad_c) begin
                if (pstate != P_IDLE) pstate <= P_FLUSH;
            end else if (byte_valid) begin
                case (pstate)
                    P_IDLE: begin
                        if (is_letter_c) begin
                            code_q <= byte_data;
                            pstate <= P_COLON;
                        end else if (!is_eol_c) begin
                            cmd_err <= 1'b1;
                            pstate  <= P_FLUSH;
                        end
                    end
                    P_COLON: begin
                        if (byte_data == 8'h3A) begin
                            acc    <= '0;
                            dcnt   <= '0;
                            pstate <= P_DIGIT;
                        end else begin
                            cmd_err <= 1'b1;
                            pstate  <= P_FLUSH;
                        end
                    end
                    P_DIGIT: begin
                        if (is_digit_c) begin
                            if (dcnt == 2'd3) begin
                                cmd_err <= 1'b1;
                                pstate  <= P_FLUSH;
                            end else begin
                                acc  <= 10'(acc * 10'd10) + {6'd0, byte_data[3:0]};
                                dcnt <= dcnt + 2'd1;
                            end
                        end else if (is_eol_c) begin
                            if (dcnt != 2'd0) begin
                                cmd_valid <= 1'b1;
                                cmd_code  <= code_q;
                                cmd_value <= acc;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                            pstate <= P_IDLE;
                        end else begin
                            cmd_err <= 1'b1;
                            pstate  <= P_FLUSH;
                        end
                    end
                    P_FLUSH: begin
                        if (is_eol_c) pstate <= P_IDLE;
                    end
                    default: pstate <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx; scaled clock so one bit is 64 clocks (DIV=4, OVS=16).
module tb_uart_cmd_rx;

    localparam int unsigned BAUD     = 9600;
    localparam int unsigned OVS      = 16;
    localparam int unsigned CLK_FREQ = BAUD * OVS * 4;
    localparam int          BIT      = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [9:0] cmd_value;
    logic       cmd_err;

    int n_checks = 0;
    int n_fail   = 0;

    int n_bv = 0, n_cv = 0, n_err = 0, n_both = 0;
    int cyc = 0, last_bv_cyc = 0, cv_lat = -1, err_lat = -1;
    logic [7:0] last_code  = 8'h00;
    logic [9:0] last_value = 10'd0;
`ifdef UART_CMD_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_value(cmd_value),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (byte_valid) begin
            n_bv = n_bv + 1;
            last_bv_cyc = cyc;
        end
        if (cmd_valid) begin
            n_cv = n_cv + 1;
            last_code  = cmd_code;
            last_value = cmd_value;
            cv_lat = cyc - last_bv_cyc;
        end
        if (cmd_err) begin
            n_err = n_err + 1;
            err_lat = cyc - last_bv_cyc;
        end
        if (cmd_valid && cmd_err) n_both = n_both + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT);
        end
`ifdef UART_CMD_PARITY_EN
        rx = (^b) ^ par_flip;
        wait_clk(BIT);
`endif
        rx = stop_bit;
        wait_clk(BIT);
        rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        wait_clk(8);
    endtask

    task automatic expect_cmd(input string name, input int dcv, input int derr,
                              input logic [7:0] code, input logic [9:0] value,
                              input int cv0, input int err0);
        n_checks++;
        if (n_cv - cv0 !== dcv) begin
            n_fail++;
            $display("FAIL %s cmd_valid count: got %0d want %0d", name, n_cv - cv0, dcv);
        end
        n_checks++;
        if (n_err - err0 !== derr) begin
            n_fail++;
            $display("FAIL %s cmd_err count: got %0d want %0d", name, n_err - err0, derr);
        end
        if (dcv > 0) begin
            n_checks++;
            if (last_code !== code) begin
                n_fail++;
                $display("FAIL %s cmd_code: got %h want %h", name, last_code, code);
            end
            n_checks++;
            if (last_value !== value) begin
                n_fail++;
                $display("FAIL %s cmd_value: got %0d want %0d", name, last_value, value);
            end
        end
    endtask

    task automatic test_reset();
        rx = 1'b1;
        reset = 1'b0;
        wait_clk(5);
        n_checks++;
        if ({byte_valid, byte_data, cmd_valid, cmd_code, cmd_value, cmd_err} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h want 0",
                     {byte_valid, byte_data, cmd_valid, cmd_code, cmd_value, cmd_err});
        end
        reset = 1'b1;
        wait_clk(BIT);
    endtask

    task automatic test_basic();
        int cv0 = n_cv, err0 = n_err, bv0 = n_bv;
        send_str("M:1\r");
        expect_cmd("basic", 1, 0, 8'h4D, 10'd1, cv0, err0);
        n_checks++;
        if (n_bv - bv0 !== 4) begin
            n_fail++;
            $display("FAIL basic byte_valid count: got %0d want 4", n_bv - bv0);
        end
        n_checks++;
        if (byte_data !== 8'h0D) begin
            n_fail++;
            $display("FAIL basic byte_data: got %h want 0d", byte_data);
        end
        n_checks++;
        if (cv_lat !== 1) begin
            n_fail++;
            $display("FAIL basic cmd_valid latency: got %0d want 1", cv_lat);
        end
    endtask

    task automatic test_back_to_back();
        int cv0 = n_cv, err0 = n_err;
        send_str("T:255\n");
        expect_cmd("b2b T", 1, 0, 8'h54, 10'd255, cv0, err0);
        cv0 = n_cv;
        err0 = n_err;
        send_str("\rD:999\n");
        expect_cmd("b2b D", 1, 0, 8'h44, 10'd999, cv0, err0);
    endtask

    task automatic test_overflow();
        int cv0 = n_cv, err0 = n_err;
        send_str("S:1234\r");
        expect_cmd("overflow", 0, 1, 8'h00, 10'd0, cv0, err0);
        n_checks++;
        if (err_lat !== 1) begin
            n_fail++;
            $display("FAIL overflow cmd_err latency: got %0d want 1", err_lat);
        end
        cv0 = n_cv;
        err0 = n_err;
        send_str("F:3\r");
        expect_cmd("after overflow", 1, 0, 8'h46, 10'd3, cv0, err0);
    endtask

    task automatic test_syntax();
        int cv0 = n_cv, err0 = n_err;
        send_str("Q:\r");
        expect_cmd("no digits", 0, 1, 8'h00, 10'd0, cv0, err0);
        cv0 = n_cv;
        err0 = n_err;
        send_str("?:1\rK7\r");
        expect_cmd("bad letter/colon", 0, 2, 8'h00, 10'd0, cv0, err0);
    endtask

    task automatic test_glitch_framing();
        int cv0 = n_cv, err0 = n_err, bv0 = n_bv;
        rx = 1'b0;
        wait_clk(8);
        rx = 1'b1;
        wait_clk(3 * BIT);
        n_checks++;
        if (n_bv - bv0 !== 0 || n_err - err0 !== 0) begin
            n_fail++;
            $display("FAIL glitch strobes: got bv=%0d err=%0d want 0 0", n_bv - bv0, n_err - err0);
        end
        send_byte(8'h5A, 1'b0);
        wait_clk(2 * BIT);
        n_checks++;
        if (n_bv - bv0 !== 0) begin
            n_fail++;
            $display("FAIL framing byte_valid count: got %0d want 0", n_bv - bv0);
        end
        expect_cmd("framing", 0, 1, 8'h00, 10'd0, cv0, err0);
        cv0 = n_cv;
        err0 = n_err;
        send_str("A:7\r");
        expect_cmd("after framing", 1, 0, 8'h41, 10'd7, cv0, err0);
    endtask

    task automatic test_reset_midframe();
        int cv0, err0, bv0;
        send_str("H:5");
        rx = 1'b0;
        wait_clk(BIT + 20);
        rx = 1'b1;
        reset = 1'b0;
        wait_clk(3);
        n_checks++;
        if ({byte_valid, byte_data, cmd_valid, cmd_code, cmd_value, cmd_err} !== 29'd0) begin
            n_fail++;
            $display("FAIL midframe reset outputs: got %h want 0",
                     {byte_valid, byte_data, cmd_valid, cmd_code, cmd_value, cmd_err});
        end
        reset = 1'b1;
        cv0 = n_cv;
        err0 = n_err;
        bv0 = n_bv;
        wait_clk(4 * BIT);
        n_checks++;
        if (n_cv - cv0 + n_err - err0 + n_bv - bv0 !== 0) begin
            n_fail++;
            $display("FAIL stale strobe after reset: got %0d want 0",
                     n_cv - cv0 + n_err - err0 + n_bv - bv0);
        end
        send_str("H:60\r");
        expect_cmd("after reset", 1, 0, 8'h48, 10'd60, cv0, err0);
    endtask

`ifdef UART_CMD_PARITY_EN
    task automatic test_parity();
        int cv0 = n_cv, err0 = n_err;
        send_str("T:20\r");
        expect_cmd("parity ok", 1, 0, 8'h54, 10'd20, cv0, err0);
        cv0 = n_cv;
        err0 = n_err;
        send_byte(8'h54, 1'b1);
        send_byte(8'h3A, 1'b1);
        par_flip = 1'b1;
        send_byte(8'h32, 1'b1);
        par_flip = 1'b0;
        send_str("0\r");
        expect_cmd("parity bad", 0, 1, 8'h00, 10'd0, cv0, err0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_syntax();
        test_glitch_framing();
        test_reset_midframe();
`ifdef UART_CMD_PARITY_EN
        test_parity();
`endif
        n_checks++;
        if (n_both !== 0) begin
            n_fail++;
            $display("FAIL valid/err overlap: got %0d cycles want 0", n_both);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
